// File: rtl/store_pkg.sv
// Shared encodings for the store data aligner: access sizes, lane masks and FSM states.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;

endpackage

// File: rtl/store_data_aligner_if.sv
// Store request channel and data-memory beat channel of the store data aligner.
interface store_data_aligner_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              misalign_err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign_err
  );
endinterface

// File: rtl/store_lane_shifter.sv
// Combinational lane placement: masks store data to its size and shifts data and
// byte enables across a two-word (64-bit) window starting at the byte offset.
module store_lane_shifter
  import store_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  input  size_e       size,
  output logic [63:0] d64,
  output logic [7:0]  be8,
  output logic        misaligned
);

  logic [3:0]  mask;
  logic [31:0] data_m;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mask   = 4'b0000;
    data_m = 32'h0;
    case (size)
      SZ_BYTE: begin mask = MASK_BYTE; data_m = {24'h0, data[7:0]};  end
      SZ_HALF: begin mask = MASK_HALF; data_m = {16'h0, data[15:0]}; end
      SZ_WORD: begin mask = MASK_WORD; data_m = data;                end
      default: ;
    endcase
    d64        = {32'h0, data_m} << {offset, 3'b000};
    be8        = {4'b0000, mask} << offset;
    misaligned = ((size == SZ_HALF) && (offset == 2'd3)) ||
                 ((size == SZ_WORD) && (offset != 2'd0));
  end

endmodule

// File: rtl/store_data_aligner.sv
// MEM-stage store aligner: turns sb/sh/sw into word-aligned byte-enabled memory beats.
// Define STORE_UNALIGNED_SPLIT_EN to split lane-crossing stores into two beats.
module store_data_aligner
  import store_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  store_data_aligner_if.slave  bus
);

  logic [1:0]  state;
  logic [63:0] d64;
  logic [7:0]  be8;
  logic        misaligned;
  logic        final_beat;
  logic        req_err;
  logic        accept;
  size_e       size;

  assign size = size_e'(bus.req_size);

  store_lane_shifter u_shifter (
    .offset     (bus.req_addr[1:0]),
    .data       (bus.req_data),
    .size       (size),
    .d64        (d64),
    .be8        (be8),
    .misaligned (misaligned)
  );

`ifdef STORE_UNALIGNED_SPLIT_EN
  logic        split_pending;
  logic [31:0] hi_wdata;
  logic [3:0]  hi_be;

  assign final_beat = (state == ST_BEAT1) || ((state == ST_BEAT0) && !split_pending);
  assign req_err    = (size == SZ_RSVD);
`else
  logic unused_hi;

  assign unused_hi  = ^{d64[63:32], be8[7:4]};
  assign final_beat = (state == ST_BEAT0);
  assign req_err    = (size == SZ_RSVD) || misaligned;
`endif

  // Accepting in the final-beat handoff cycle lets the next beat follow with no bubble.
  assign bus.req_ready = (state == ST_IDLE) || (bus.mem_valid && bus.mem_ready && final_beat);
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Reset) begin
      state            <= ST_IDLE;
      bus.mem_valid    <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= 32'h0;
      bus.mem_be       <= 4'h0;
      bus.misalign_err <= 1'b0;
`ifdef STORE_UNALIGNED_SPLIT_EN
      split_pending    <= 1'b0;
      hi_wdata         <= 32'h0;
      hi_be            <= 4'h0;
`endif
    end else begin
      bus.misalign_err <= 1'b0;
      if (accept) begin
        if (req_err) begin
          bus.misalign_err <= 1'b1;
          bus.mem_valid    <= 1'b0;
          state            <= ST_IDLE;
        end else begin
          bus.mem_valid <= 1'b1;
          bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
          bus.mem_wdata <= d64[31:0];
          bus.mem_be    <= be8[3:0];
          state         <= ST_BEAT0;
`ifdef STORE_UNALIGNED_SPLIT_EN
          split_pending <= misaligned;
          hi_wdata      <= d64[63:32];
          hi_be         <= be8[7:4];
`endif
        end
      end else if (bus.mem_valid && bus.mem_ready) begin
`ifdef STORE_UNALIGNED_SPLIT_EN
        if ((state == ST_BEAT0) && split_pending) begin
          // Upper beat goes to the next word; the add wraps at the top of the space.
          bus.mem_addr  <= bus.mem_addr + ADDR_W'(4);
          bus.mem_wdata <= hi_wdata;
          bus.mem_be    <= hi_be;
          split_pending <= 1'b0;
          state         <= ST_BEAT1;
        end else begin
          bus.mem_valid <= 1'b0;
          state         <= ST_IDLE;
        end
`else
        bus.mem_valid <= 1'b0;
        state         <= ST_IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_store_data_aligner.sv
// Directed self-checking bench for store_data_aligner; expectations follow the
// STORE_UNALIGNED_SPLIT_EN setting of the build.
module tb_store_data_aligner;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fail;

  store_data_aligner_if #(.ADDR_W(32)) bus ();

  store_data_aligner #(.ADDR_W(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    check({tag, "_valid"}, {31'h0, bus.mem_valid}, 32'h1);
    check({tag, "_addr"},  bus.mem_addr, a);
    check({tag, "_wdata"}, bus.mem_wdata, d);
    check({tag, "_be"},    {28'h0, bus.mem_be}, {28'h0, be});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset    = 1'b1;
    bus.mem_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check("rst_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("rst_addr",  bus.mem_addr, 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_be",    {28'h0, bus.mem_be}, 32'h0);
    check("rst_err",   {31'h0, bus.misalign_err}, 32'h0);
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);

    // 1: sb to top lane
    drive(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check_beat("sb", 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    tick();
    check("sb_done", {31'h0, bus.mem_valid}, 32'h0);

    // 2: sh with memory stalled for three cycles
    bus.mem_ready = 1'b0;
    drive(1'b1, 32'h0000_2002, 32'h0000_1234, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_beat("sh_stall", 32'h0000_2000, 32'h1234_0000, 4'b1100);
      check("sh_stall_ready", {31'h0, bus.req_ready}, 32'h0);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("sh_handoff_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    check("sh_done", {31'h0, bus.mem_valid}, 32'h0);

    // 3: back-to-back aligned words, no bubble
    drive(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 2'b10);
    tick();
    drive(1'b1, 32'h0000_3004, 32'h5566_7788, 2'b10);
    #1;
    check_beat("sw0", 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111);
    check("sw0_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check_beat("sw1", 32'h0000_3004, 32'h5566_7788, 4'b1111);
    tick();
    check("sw_done", {31'h0, bus.mem_valid}, 32'h0);

    // 4: misaligned word
    drive(1'b1, 32'h0000_4001, 32'h1122_3344, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
`ifdef STORE_UNALIGNED_SPLIT_EN
    check_beat("mw_b0", 32'h0000_4000, 32'h2233_4400, 4'b1110);
    check("mw_b0_err", {31'h0, bus.misalign_err}, 32'h0);
    check("mw_b0_ready", {31'h0, bus.req_ready}, 32'h0);
    tick();
    check_beat("mw_b1", 32'h0000_4004, 32'h0000_0011, 4'b0001);
    check("mw_b1_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    check("mw_done", {31'h0, bus.mem_valid}, 32'h0);
`else
    check("mw_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("mw_err", {31'h0, bus.misalign_err}, 32'h1);
    tick();
    check("mw_err_clr", {31'h0, bus.misalign_err}, 32'h0);
`endif

    // 5: reserved size is always rejected
    drive(1'b1, 32'h0000_5002, 32'hCAFE_F00D, 2'b11);
    #1;
    check("rsvd_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check("rsvd_err", {31'h0, bus.misalign_err}, 32'h1);
    check("rsvd_valid", {31'h0, bus.mem_valid}, 32'h0);
    tick();
    check("rsvd_err_clr", {31'h0, bus.misalign_err}, 32'h0);
    check("rsvd_still_idle", {31'h0, bus.mem_valid}, 32'h0);

    // Address wrap: half at the last byte of the address space
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
`ifdef STORE_UNALIGNED_SPLIT_EN
    check_beat("wrap_b0", 32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000);
    check("wrap_b0_err", {31'h0, bus.misalign_err}, 32'h0);
    tick();
    check_beat("wrap_b1", 32'h0000_0000, 32'h0000_00BE, 4'b0001);
    tick();
    check("wrap_done", {31'h0, bus.mem_valid}, 32'h0);
`else
    check("wrap_err", {31'h0, bus.misalign_err}, 32'h1);
    check("wrap_valid", {31'h0, bus.mem_valid}, 32'h0);
    tick();
`endif

    // 6: reset while the first beat is stalled
    bus.mem_ready = 1'b0;
`ifdef STORE_UNALIGNED_SPLIT_EN
    drive(1'b1, 32'h0000_6002, 32'hA1B2_C3D4, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check_beat("rstmid_b0", 32'h0000_6000, 32'hC3D4_0000, 4'b1100);
`else
    drive(1'b1, 32'h0000_6000, 32'hA1B2_C3D4, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check_beat("rstmid_b0", 32'h0000_6000, 32'hA1B2_C3D4, 4'b1111);
`endif
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("rstmid_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("rstmid_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rstmid_be", {28'h0, bus.mem_be}, 32'h0);
    tick();
    check("rstmid_no_b1", {31'h0, bus.mem_valid}, 32'h0);
    tick();
    check("rstmid_no_b1_late", {31'h0, bus.mem_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
